speed_pwm_out: RTL and testbench

- Downstream of the DShot speed decoder; consumes its 8-bit throttle and re-emits it as a standard 1000–2000 us servo/ESC PWM pulse at a fixed frame rate.
- Adds arming (consecutive zero-throttle frames required before any pulse is driven) and a failsafe that drops to minimum throttle when decoded updates stop.
- Pulse width changes only at frame boundaries, so the output never carries a runt or glitched pulse.

---
 rtl/dshot_pkg.sv | 38 +++
 rtl/speed_pwm_out_if.sv | 35 +++
 rtl/pwm_frame_timer.sv | 75 +++++++
 rtl/speed_pwm_out.sv | 193 +++++++++++++++++++
 tb/tb_speed_pwm_out.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dshot_pkg.sv
// -----------------------------------------------------------------------------
// dshot_pkg
// Shared types and helpers for the DShot-to-PWM output path.
//   state_t        : arming/failsafe state machine encoding
//   TICK_W         : width of every tick counter / pulse width value
//   ticks_per_us   : clock cycles per microsecond for a given clock rate
//   speed_to_ticks : maps an 8-bit throttle to a pulse width in clock ticks
// -----------------------------------------------------------------------------
package dshot_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    ARMED    = 2'd2,
    FAILSAFE = 2'd3
  } state_t;

  // Frame and pulse counters share this width; the frame length in ticks
  // must stay below 2**TICK_W.
  localparam int TICK_W = 16;

  function automatic int ticks_per_us(input int clk_hz);
    return clk_hz / 1000000;
  endfunction

  // min_ticks + floor(speed * span_ticks / 256). The product is held at
  // full width (8 + TICK_W bits) so nothing is lost before the shift.
  function automatic logic [TICK_W-1:0] speed_to_ticks(
    input logic [7:0]        speed,
    input logic [TICK_W-1:0] min_ticks,
    input logic [TICK_W-1:0] span_ticks
  );
    logic [TICK_W+7:0] prod;
    prod = {{TICK_W{1'b0}}, speed} * {8'd0, span_ticks};
    return min_ticks + TICK_W'(prod >> 8);
  endfunction

endpackage

// File: rtl/speed_pwm_out_if.sv
// -----------------------------------------------------------------------------
// speed_pwm_out_if
// Bundles the decoder-side inputs and the ESC-side outputs of speed_pwm_out.
//   speed[7:0]  : throttle from the DShot decoder
//   speed_valid : new-frame indication (edge detected inside the block)
//   pwm_out     : servo/ESC PWM pulse
//   armed       : high while the block is armed
//   failsafe    : high while the block is in failsafe
// master = decoder/testbench side, slave = speed_pwm_out.
// -----------------------------------------------------------------------------
interface speed_pwm_out_if;

  logic [7:0] speed;
  logic       speed_valid;
  logic       pwm_out;
  logic       armed;
  logic       failsafe;

  modport master (
    output speed,
    output speed_valid,
    input  pwm_out,
    input  armed,
    input  failsafe
  );

  modport slave (
    input  speed,
    input  speed_valid,
    output pwm_out,
    output armed,
    output failsafe
  );

endinterface

// File: rtl/pwm_frame_timer.sv
// -----------------------------------------------------------------------------
// pwm_frame_timer
// Free-running frame counter and pulse generator. The pulse width and the
// output enable are latched only on the last tick of a frame, so every
// emitted pulse is complete and starts at frame_cnt == 0.
//   clk, rst_n   : clock, asynchronous active-low reset
//   target_ticks : pulse width to use for the next frame
//   drive_req    : enable to use for the next frame
//   boundary     : high on the last tick of each frame
//   pwm_out      : registered PWM output
// -----------------------------------------------------------------------------
module pwm_frame_timer
  import dshot_pkg::*;
#(
  parameter int FRAME_TICKS = 40000,
  parameter int MIN_TICKS   = 16000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TICK_W-1:0] target_ticks,
  input  logic              drive_req,
  output logic              boundary,
  output logic              pwm_out
);

  logic [TICK_W-1:0] frame_cnt_r;
  logic [TICK_W-1:0] pulse_ticks_r;
  logic              drive_en_r;
  logic              pwm_r;

  logic [TICK_W-1:0] frame_nxt_s;
  logic [TICK_W-1:0] pulse_nxt_s;
  logic              drive_nxt_s;
  logic              pwm_nxt_s;
  logic              boundary_s;

  assign boundary_s = (frame_cnt_r == TICK_W'(FRAME_TICKS - 1));
  assign boundary   = boundary_s;
  assign pwm_out    = pwm_r;

  // Next frame position, latched width/enable, and the output they imply.
  always_comb begin
    frame_nxt_s = frame_cnt_r;
    pulse_nxt_s = pulse_ticks_r;
    drive_nxt_s = drive_en_r;
    if (boundary_s) begin
      frame_nxt_s = {TICK_W{1'b0}};
      pulse_nxt_s = target_ticks;
      drive_nxt_s = drive_req;
    end else begin
      frame_nxt_s = frame_cnt_r + TICK_W'(1);
      pulse_nxt_s = pulse_ticks_r;
      drive_nxt_s = drive_en_r;
    end
    // Evaluated on next-cycle values so the registered output lines up
    // with frame_cnt: high exactly while frame_cnt < pulse_ticks.
    pwm_nxt_s = drive_nxt_s & (frame_nxt_s < pulse_nxt_s);
  end

  // Frame counter, latched pulse parameters and registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r   <= {TICK_W{1'b0}};
      pulse_ticks_r <= TICK_W'(MIN_TICKS);
      drive_en_r    <= 1'b0;
      pwm_r         <= 1'b0;
    end else begin
      frame_cnt_r   <= frame_nxt_s;
      pulse_ticks_r <= pulse_nxt_s;
      drive_en_r    <= drive_nxt_s;
      pwm_r         <= pwm_nxt_s;
    end
  end

endmodule

// File: rtl/speed_pwm_out.sv
// -----------------------------------------------------------------------------
// speed_pwm_out
// Re-emits the decoded DShot throttle as a 1000-2000 us servo/ESC pulse at a
// fixed frame rate, with zero-throttle arming and a timeout failsafe.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : speed_pwm_out_if.slave (speed, speed_valid in; pwm_out, armed,
//           failsafe out; all outputs registered)
// The top holds the speed_valid edge detector, the shadow speed register and
// the arming state machine; pwm_frame_timer owns the frame and pulse timing.
// ARM_COUNT is expected to be at least 2.
// -----------------------------------------------------------------------------
module speed_pwm_out
  import dshot_pkg::*;
#(
  parameter int CLK_HZ         = 16000000,
  parameter int FRAME_US       = 2500,
  parameter int MIN_US         = 1000,
  parameter int MAX_US         = 2000,
  parameter int ARM_COUNT      = 10,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  speed_pwm_out_if.slave  bus
);

  localparam int TICKS_PER_US = ticks_per_us(CLK_HZ);
  localparam int FRAME_TICKS  = FRAME_US * TICKS_PER_US;
  localparam int MIN_TICKS    = MIN_US * TICKS_PER_US;
  localparam int SPAN_TICKS   = (MAX_US - MIN_US) * TICKS_PER_US;
  localparam int ARM_W        = $clog2(ARM_COUNT + 1);
  localparam int TO_W         = $clog2(TIMEOUT_FRAMES + 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic              valid_d_r;
  logic [7:0]        shadow_r;
  logic [ARM_W-1:0]  arm_cnt_r;
  logic [ARM_W-1:0]  arm_nxt_s;
  logic [ARM_W-1:0]  arm_inc_s;
  logic [TO_W-1:0]   timeout_cnt_r;
  logic [TO_W-1:0]   timeout_nxt_s;
  logic              upd_seen_r;
  logic              upd_seen_nxt_s;
  logic              armed_r;
  logic              failsafe_r;

  logic              update_s;
  logic              speed_zero_s;
  logic              boundary_s;
  logic              force_min_s;
  logic              drive_req_s;
  logic [7:0]        calc_speed_s;
  logic [TICK_W-1:0] target_ticks_s;
  logic              pwm_s;

  // A held-high speed_valid is one update: only the rising edge counts.
  assign update_s     = bus.speed_valid & ~valid_d_r;
  assign speed_zero_s = (bus.speed == 8'd0);
  assign arm_inc_s    = arm_cnt_r + ARM_W'(1);

  // Arming / timeout state machine: next state and counters.
  always_comb begin
    state_nxt_s    = state_r;
    arm_nxt_s      = arm_cnt_r;
    timeout_nxt_s  = timeout_cnt_r;
    upd_seen_nxt_s = upd_seen_r;

    // An update landing on the boundary cycle is consumed by that boundary.
    if (boundary_s) begin
      upd_seen_nxt_s = 1'b0;
    end else if (update_s) begin
      upd_seen_nxt_s = 1'b1;
    end else begin
      upd_seen_nxt_s = upd_seen_r;
    end

    case (state_r)
      DISARMED: begin
        timeout_nxt_s = {TO_W{1'b0}};
        if (update_s && speed_zero_s) begin
          arm_nxt_s   = ARM_W'(1);
          state_nxt_s = ARMING;
        end else begin
          arm_nxt_s   = {ARM_W{1'b0}};
        end
      end
      ARMING: begin
        timeout_nxt_s = {TO_W{1'b0}};
        if (update_s && speed_zero_s) begin
          arm_nxt_s = arm_inc_s;
          if (arm_inc_s == ARM_W'(ARM_COUNT)) begin
            state_nxt_s = ARMED;
          end else begin
            state_nxt_s = ARMING;
          end
        end else if (update_s) begin
          arm_nxt_s   = {ARM_W{1'b0}};
          state_nxt_s = DISARMED;
        end else begin
          arm_nxt_s   = arm_cnt_r;
        end
      end
      ARMED: begin
        arm_nxt_s = {ARM_W{1'b0}};
        if (update_s) begin
          timeout_nxt_s = {TO_W{1'b0}};
        end else if (boundary_s && !upd_seen_r) begin
          if (timeout_cnt_r == TO_W'(TIMEOUT_FRAMES - 1)) begin
            timeout_nxt_s = {TO_W{1'b0}};
            state_nxt_s   = FAILSAFE;
          end else begin
            timeout_nxt_s = timeout_cnt_r + TO_W'(1);
          end
        end else begin
          timeout_nxt_s = timeout_cnt_r;
        end
      end
      FAILSAFE: begin
        timeout_nxt_s = {TO_W{1'b0}};
        if (update_s && speed_zero_s) begin
          arm_nxt_s   = ARM_W'(1);
          state_nxt_s = ARMING;
        end else begin
          arm_nxt_s   = {ARM_W{1'b0}};
        end
      end
      default: begin
        state_nxt_s   = DISARMED;
        arm_nxt_s     = {ARM_W{1'b0}};
        timeout_nxt_s = {TO_W{1'b0}};
      end
    endcase
  end

  // Pulse request for the next frame. Minimum width is forced both while in
  // failsafe and on the boundary that enters it, so the first failsafe frame
  // is already at minimum and leaving failsafe never flashes a stale width.
  always_comb begin
    force_min_s = (state_r == FAILSAFE) || (state_nxt_s == FAILSAFE);
    drive_req_s = (state_r == ARMED) || (state_r == FAILSAFE);
    if (force_min_s) begin
      calc_speed_s = 8'd0;
    end else begin
      calc_speed_s = shadow_r;
    end
    target_ticks_s = speed_to_ticks(calc_speed_s, TICK_W'(MIN_TICKS),
                                    TICK_W'(SPAN_TICKS));
  end

  // Edge detector, shadow speed, state, counters and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d_r     <= 1'b0;
      shadow_r      <= 8'd0;
      state_r       <= DISARMED;
      arm_cnt_r     <= {ARM_W{1'b0}};
      timeout_cnt_r <= {TO_W{1'b0}};
      upd_seen_r    <= 1'b0;
      armed_r       <= 1'b0;
      failsafe_r    <= 1'b0;
    end else begin
      valid_d_r     <= bus.speed_valid;
      if (update_s) begin
        shadow_r    <= bus.speed;
      end
      state_r       <= state_nxt_s;
      arm_cnt_r     <= arm_nxt_s;
      timeout_cnt_r <= timeout_nxt_s;
      upd_seen_r    <= upd_seen_nxt_s;
      armed_r       <= (state_nxt_s == ARMED);
      failsafe_r    <= (state_nxt_s == FAILSAFE);
    end
  end

  pwm_frame_timer #(
    .FRAME_TICKS (FRAME_TICKS),
    .MIN_TICKS   (MIN_TICKS)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .target_ticks (target_ticks_s),
    .drive_req    (drive_req_s),
    .boundary     (boundary_s),
    .pwm_out      (pwm_s)
  );

  assign bus.pwm_out  = pwm_s;
  assign bus.armed    = armed_r;
  assign bus.failsafe = failsafe_r;

endmodule

// File: tb/tb_speed_pwm_out.sv
// -----------------------------------------------------------------------------
// tb_speed_pwm_out
// Directed bench for speed_pwm_out, scaled to CLK_HZ = 1 MHz (1 tick = 1 us),
// FRAME_US = 1250, MIN_US = 500, MAX_US = 1000 so the run stays short.
// Hand-computed widths: speed 0 -> 500, 128 -> 750, 200 -> 890, 255 -> 998.
// -----------------------------------------------------------------------------
module tb_speed_pwm_out;

  localparam int FT    = 1250;
  localparam int LIMIT = 3 * FT;

  logic clk = 1'b0;
  logic rst_n;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  speed_pwm_out_if bus();

  speed_pwm_out #(
    .CLK_HZ         (1000000),
    .FRAME_US       (1250),
    .MIN_US         (500),
    .MAX_US         (1000),
    .ARM_COUNT      (10),
    .TIMEOUT_FRAMES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_update(input logic [7:0] s);
    @(negedge clk);
    bus.speed       = s;
    bus.speed_valid = 1'b1;
    @(negedge clk);
    bus.speed_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (bus.pwm_out === 1'b1 && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (bus.pwm_out === 1'b0 && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic count_high_window(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.pwm_out !== 1'b0) n++;
    end
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.speed       = 8'd0;
    bus.speed_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hi;
    int lo;
    int n;

    // ---- reset and idle ----
    rst_n           = 1'b0;
    bus.speed       = 8'd0;
    bus.speed_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pwm", bus.pwm_out, 0);
    check("reset_armed", bus.armed, 0);
    check("reset_failsafe", bus.failsafe, 0);
    rst_n = 1'b1;
    count_high_window(3 * FT, n);
    check("idle_no_pulse", n, 0);
    check("idle_armed", bus.armed, 0);
    check("idle_failsafe", bus.failsafe, 0);

    // ---- arm with 10 zero updates ----
    repeat (9) send_update(8'd0);
    check("arm_after_9", bus.armed, 0);
    send_update(8'd0);
    check("arm_after_10", bus.armed, 1);
    check("arm_failsafe", bus.failsafe, 0);
    count_low(lo);
    count_high(hi);
    check("first_pulse_w0", hi, 500);
    count_low(lo);
    check("frame_period", hi + lo, FT);

    // ---- width change only at frame boundary ----
    send_update(8'd128);
    count_high(hi);
    check("old_width_kept", hi, 497);
    count_low(lo);
    check("old_width_low", lo, 750);
    count_high(hi);
    check("w128", hi, 750);
    count_low(lo);
    check("w128_low", lo, 500);
    send_update(8'd255);
    count_high(hi);
    check("w128_kept", hi, 747);
    count_low(lo);
    count_high(hi);
    check("w255_floor", hi, 998);
    count_low(lo);
    check("w255_low", lo, 252);
    check("no_failsafe_busy", bus.failsafe, 0);

    // ---- nonzero update during arming restarts the count ----
    do_reset();
    repeat (5) send_update(8'd0);
    send_update(8'd7);
    repeat (9) send_update(8'd0);
    check("arming_9_after_abort", bus.armed, 0);
    count_high_window(2 * FT, n);
    check("arming_no_pulse", n, 0);
    send_update(8'd0);
    check("arming_10th", bus.armed, 1);
    count_low(lo);
    count_high(hi);
    check("rearm_pulse_w0", hi, 500);
    count_low(lo);

    // ---- failsafe after 4 empty boundaries ----
    send_update(8'd200);
    count_high(hi);
    check("pre200_kept", hi, 497);
    count_low(lo);
    count_high(hi);
    check("w200", hi, 890);
    count_low(lo);
    count_high(hi);
    count_low(lo);
    count_high(hi);
    count_low(lo);
    check("no_failsafe_at_3", bus.failsafe, 0);
    count_high(hi);
    check("w200_last", hi, 890);
    count_low(lo);
    check("failsafe_at_4", bus.failsafe, 1);
    check("failsafe_not_armed", bus.armed, 0);
    count_high(hi);
    check("failsafe_min", hi, 500);
    count_low(lo);
    check("failsafe_min_low", lo, 750);

    // ---- recover from failsafe ----
    send_update(8'd0);
    check("recover_failsafe_clr", bus.failsafe, 0);
    check("recover_not_armed", bus.armed, 0);
    count_high(hi);
    check("recover_last_pulse", hi, 497);
    count_high_window(2 * FT, n);
    check("recover_output_low", n, 0);
    repeat (8) send_update(8'd0);
    check("recover_9_zeros", bus.armed, 0);
    send_update(8'd0);
    check("recover_armed", bus.armed, 1);
    count_low(lo);
    count_high(hi);
    check("recover_pulse_w0", hi, 500);

    // ---- held-high speed_valid counts once ----
    do_reset();
    @(negedge clk);
    bus.speed       = 8'd0;
    bus.speed_valid = 1'b1;
    repeat (1000) @(negedge clk);
    bus.speed_valid = 1'b0;
    @(negedge clk);
    check("held_not_armed", bus.armed, 0);
    repeat (8) send_update(8'd0);
    check("held_counts_once", bus.armed, 0);
    send_update(8'd0);
    check("held_then_armed", bus.armed, 1);

    // ---- reset mid-pulse ----
    count_low(lo);
    repeat (100) @(negedge clk);
    check("mid_pulse_high", bus.pwm_out, 1);
    rst_n = 1'b0;
    #1;
    check("reset_drops_pwm", bus.pwm_out, 0);
    check("reset_clears_armed", bus.armed, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_high_window(FT + 10, n);
    check("post_reset_no_pulse", n, 0);
    check("post_reset_disarmed", bus.armed, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
